// File: rtl/mod_counter_seg_if.sv
// Control and display bundle for the modulo-N counter.
// The master side supplies enable, clear and terminal count; the slave side
// (the counter itself) returns the count, the wrap tick and the segment drive.
interface mod_counter_seg_if;
  logic       en;
  logic       clear;
  logic [3:0] limit;
  logic [3:0] count;
  logic       tick;
  logic [6:0] seg;

  modport master (
    output en,
    output clear,
    output limit,
    input  count,
    input  tick,
    input  seg
  );

  modport slave (
    input  en,
    input  clear,
    input  limit,
    output count,
    output tick,
    output seg
  );
endinterface : mod_counter_seg_if

// File: rtl/mod_counter_seg.sv
// Programmable modulo-N counter with a prescaler, a registered wrap tick and
// an active-low 7-segment hex decode of the current count.
// The terminal count is latched at reset, clear or wrap only, so a change on
// the limit input never truncates or extends the period in progress.
module mod_counter_seg #(
  parameter int PRESCALE = 1,
  parameter int PS_WIDTH = 24
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mod_counter_seg_if.slave  cnt_bus
);

  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] psc_q, psc_d;
  logic [3:0]          lim_q, lim_d;
  logic [3:0]          count_q, count_d;
  logic                tick_q, tick_d;
  logic                step_s;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'h0:    pat = 7'b1000000;
      4'h1:    pat = 7'b1111001;
      4'h2:    pat = 7'b0100100;
      4'h3:    pat = 7'b0110000;
      4'h4:    pat = 7'b0011001;
      4'h5:    pat = 7'b0010010;
      4'h6:    pat = 7'b0000010;
      4'h7:    pat = 7'b1111000;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0010000;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b0000011;
      4'hC:    pat = 7'b1000110;
      4'hD:    pat = 7'b0100001;
      4'hE:    pat = 7'b0000110;
      4'hF:    pat = 7'b0001110;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  // Next-state logic: clear, then prescaler advance and count step or wrap.
  always_comb begin
    psc_d   = psc_q;
    lim_d   = lim_q;
    count_d = count_q;
    tick_d  = 1'b0;
    step_s  = 1'b0;
    if (cnt_bus.clear) begin
      // Restart exactly like reset; a wrap on this edge is discarded.
      psc_d   = '0;
      count_d = 4'd0;
      lim_d   = cnt_bus.limit;
    end else if (cnt_bus.en) begin
      if (psc_q == PS_LAST) begin
        psc_d  = '0;
        step_s = 1'b1;
      end else begin
        psc_d  = psc_q + PS_WIDTH'(1);
        step_s = 1'b0;
      end
      if (step_s) begin
        // ">=" keeps the counter bounded even if lim_q shrank below count_q.
        if (count_q >= lim_q) begin
          count_d = 4'd0;
          tick_d  = 1'b1;
          lim_d   = cnt_bus.limit;
        end else begin
          count_d = count_q + 4'd1;
          tick_d  = 1'b0;
        end
      end else begin
        count_d = count_q;
      end
    end else begin
      // Disabled: everything holds, tick drops.
      psc_d   = psc_q;
      count_d = count_q;
    end
  end

  // State registers with synchronous active-high reset that reloads the limit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      psc_q   <= '0;
      count_q <= 4'd0;
      tick_q  <= 1'b0;
      lim_q   <= cnt_bus.limit;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      lim_q   <= lim_d;
    end
  end

  assign cnt_bus.count = count_q;
  assign cnt_bus.tick  = tick_q;
  // Display follows the count in the same cycle with no extra register.
  assign cnt_bus.seg   = seg_decode(count_q);

endmodule : mod_counter_seg
